pmem_arbiter: RTL and testbench

Shares the single physical-memory port between the I-cache (port a, read-only) and the D-cache (port b, read/write).
- Grants one requester at a time and latches its command, address and write line.
- Steers the memory response and read data back to the granted requester only.
- D-cache has priority; a bounded-starvation counter guarantees I-cache forward progress.

---
 rtl/pmem_arbiter.sv | 112 +++++++++++
 tb/tb_pmem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between the I-cache (a) and D-cache (b).
// D-cache wins ties, with a streak counter that guarantees I-cache progress.
module pmem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int LINE_WIDTH   = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pmem_read_a,
  input  logic [ADDR_WIDTH-1:0] pmem_address_a,
  output logic [LINE_WIDTH-1:0] pmem_rdata_a,
  output logic                  pmem_resp_a,
  input  logic                  pmem_read_b,
  input  logic                  pmem_write_b,
  input  logic [ADDR_WIDTH-1:0] pmem_address_b,
  input  logic [LINE_WIDTH-1:0] pmem_wdata_b,
  output logic [LINE_WIDTH-1:0] pmem_rdata_b,
  output logic                  pmem_resp_b,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_A,
    SERVE_B,
    RECOVER
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                r_state;
  logic                  r_read;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [3:0]            r_streak;

  logic w_b_req;
  logic w_starved;
  logic w_serve_a;
  logic w_serve_b;

  assign w_b_req   = pmem_read_b | pmem_write_b;
  assign w_starved = w_b_req & pmem_read_a & (r_streak == LIMIT);
  assign w_serve_a = (r_state == SERVE_A);
  assign w_serve_b = (r_state == SERVE_B);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_streak <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          unique case (1'b1)
            w_starved, (!w_b_req && pmem_read_a): begin
              r_state  <= SERVE_A;
              r_read   <= 1'b1;
              r_write  <= 1'b0;
              r_addr   <= pmem_address_a;
              r_wdata  <= '0;
              r_streak <= '0;
            end
            (w_b_req && !w_starved): begin
              r_state <= SERVE_B;
              r_read  <= ~pmem_write_b;
              r_write <= pmem_write_b;
              r_addr  <= pmem_address_b;
              r_wdata <= pmem_wdata_b;
              if (!pmem_read_a)
                r_streak <= '0;
              else if (r_streak != LIMIT)
                r_streak <= r_streak + 4'd1;
            end
            default: r_state <= IDLE;
          endcase
        end
        SERVE_A, SERVE_B: begin
          if (pmem_resp) begin
            r_state <= RECOVER;
            r_read  <= 1'b0;
            r_write <= 1'b0;
          end
        end
        RECOVER: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pmem_read    = r_read;
  assign pmem_write   = r_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_write ? r_wdata : '0;

  // Responses only reach the side that holds the grant.
  assign pmem_resp_a  = w_serve_a & pmem_resp;
  assign pmem_rdata_a = w_serve_a ? pmem_rdata : '0;
  assign pmem_resp_b  = w_serve_b & pmem_resp;
  assign pmem_rdata_b = w_serve_b ? pmem_rdata : '0;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: grants, routing, starvation, reset.
module tb_pmem_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          pmem_read_a;
  logic [AW-1:0] pmem_address_a;
  logic [LW-1:0] pmem_rdata_a;
  logic          pmem_resp_a;
  logic          pmem_read_b;
  logic          pmem_write_b;
  logic [AW-1:0] pmem_address_b;
  logic [LW-1:0] pmem_wdata_b;
  logic [LW-1:0] pmem_rdata_b;
  logic          pmem_resp_b;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int total = 0;
  int bad   = 0;

  localparam logic [LW-1:0] RD_A  = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
  localparam logic [LW-1:0] RD_B  = 128'h0BADF00D_11112222_33334444_55556666;
  localparam logic [LW-1:0] WD_A5 = {16{8'hA5}};

  pmem_arbiter #(
    .ADDR_WIDTH(AW),
    .LINE_WIDTH(LW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pmem_read_a(pmem_read_a),
    .pmem_address_a(pmem_address_a),
    .pmem_rdata_a(pmem_rdata_a),
    .pmem_resp_a(pmem_resp_a),
    .pmem_read_b(pmem_read_b),
    .pmem_write_b(pmem_write_b),
    .pmem_address_b(pmem_address_b),
    .pmem_wdata_b(pmem_wdata_b),
    .pmem_rdata_b(pmem_rdata_b),
    .pmem_resp_b(pmem_resp_b),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pmem_read_a = 0; pmem_address_a = '0;
    pmem_read_b = 0; pmem_write_b = 0;
    pmem_address_b = '0; pmem_wdata_b = '0;
    pmem_rdata = RD_A; pmem_resp = 1'b1;
    step(); step();
    total++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      bad++; $display("FAIL reset_cmd got=%b want=00", {pmem_read, pmem_write});
    end
    total++;
    if (pmem_address !== '0 || pmem_wdata !== '0) begin
      bad++; $display("FAIL reset_addr_wdata got=%h/%h want=0", pmem_address, pmem_wdata);
    end
    total++;
    if ({pmem_resp_a, pmem_resp_b} !== 2'b00 || pmem_rdata_a !== '0 || pmem_rdata_b !== '0) begin
      bad++; $display("FAIL reset_route got=%b%b want=00", pmem_resp_a, pmem_resp_b);
    end
    total++;
    if (dut.r_streak !== 4'd0) begin
      bad++; $display("FAIL reset_streak got=%0d want=0", dut.r_streak);
    end
    reset = 1'b0;
    step();
    total++;
    if ({pmem_resp_a, pmem_resp_b, pmem_read, pmem_write} !== 4'b0000) begin
      bad++; $display("FAIL idle_resp_ignored got=%b want=0000",
        {pmem_resp_a, pmem_resp_b, pmem_read, pmem_write});
    end
    pmem_resp = 1'b0;
  endtask

  task automatic test_a_only();
    bit rb_seen = 0;
    pmem_read_a = 1; pmem_address_a = 16'h1230;
    #1;
    total++;
    if (pmem_read !== 1'b0) begin
      bad++; $display("FAIL a_cycle0 got=%b want=0", pmem_read);
    end
    step();
    total++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h1230) begin
      bad++; $display("FAIL a_cmd got=%b%b %h want=10 1230", pmem_read, pmem_write, pmem_address);
    end
    for (int i = 0; i < 2; i++) begin
      if (pmem_resp_a || pmem_resp_b) rb_seen = 1;
      step();
    end
    pmem_rdata = RD_A; pmem_resp = 1;
    #1;
    total++;
    if (pmem_resp_a !== 1'b1 || pmem_rdata_a !== RD_A) begin
      bad++; $display("FAIL a_resp got=%b %h want=1 %h", pmem_resp_a, pmem_rdata_a, RD_A);
    end
    if (pmem_resp_b || pmem_rdata_b !== '0) rb_seen = 1;
    total++;
    if (rb_seen) begin
      bad++; $display("FAIL a_no_b_resp got=1 want=0");
    end
    step();
    pmem_read_a = 0;
    #1;
    total++;
    if ({pmem_read, pmem_resp_a} !== 2'b00) begin
      bad++; $display("FAIL a_recover got=%b want=00", {pmem_read, pmem_resp_a});
    end
    pmem_resp = 0;
    step(); step();
  endtask

  task automatic test_b_write();
    pmem_write_b = 1; pmem_address_b = 16'h4440; pmem_wdata_b = WD_A5;
    step();
    total++;
    if ({pmem_read, pmem_write} !== 2'b01 || pmem_address !== 16'h4440 || pmem_wdata !== WD_A5) begin
      bad++; $display("FAIL b_write_cmd got=%b%b %h %h want=01 4440 %h",
        pmem_read, pmem_write, pmem_address, pmem_wdata, WD_A5);
    end
    step();
    pmem_rdata = RD_B; pmem_resp = 1;
    #1;
    total++;
    if (pmem_resp_b !== 1'b1 || pmem_rdata_b !== RD_B || pmem_resp_a !== 1'b0 || pmem_rdata_a !== '0) begin
      bad++; $display("FAIL b_route got=%b%b %h want=10 %h", pmem_resp_b, pmem_resp_a, pmem_rdata_b, RD_B);
    end
    step();
    pmem_write_b = 0;
    #1;
    total++;
    if ({pmem_read, pmem_write, pmem_resp_b} !== 3'b000 || pmem_wdata !== '0) begin
      bad++; $display("FAIL b_recover got=%b %h want=000 0",
        {pmem_read, pmem_write, pmem_resp_b}, pmem_wdata);
    end
    pmem_resp = 0;
    step();
    total++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      bad++; $display("FAIL b_idle got=%b want=00", {pmem_read, pmem_write});
    end
  endtask

  task automatic test_contention();
    pmem_read_a = 1; pmem_address_a = 16'h1000;
    pmem_read_b = 1; pmem_address_b = 16'h2000;
    step();
    total++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h2000) begin
      bad++; $display("FAIL cont_b_first got=%b %h want=1 2000", pmem_read, pmem_address);
    end
    pmem_resp = 1;
    #1;
    total++;
    if ({pmem_resp_b, pmem_resp_a} !== 2'b10) begin
      bad++; $display("FAIL cont_b_resp got=%b want=10", {pmem_resp_b, pmem_resp_a});
    end
    step();
    pmem_resp = 0; pmem_read_b = 0;
    step(); step();
    total++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h1000) begin
      bad++; $display("FAIL cont_a_next got=%b %h want=1 1000", pmem_read, pmem_address);
    end
    pmem_resp = 1;
    #1;
    total++;
    if ({pmem_resp_b, pmem_resp_a} !== 2'b01) begin
      bad++; $display("FAIL cont_a_resp got=%b want=01", {pmem_resp_b, pmem_resp_a});
    end
    step();
    pmem_resp = 0; pmem_read_a = 0;
    step();
  endtask

  task automatic test_starvation();
    int b_grants = 0;
    pmem_read_a = 1; pmem_address_a = 16'h7770;
    pmem_read_b = 1; pmem_address_b = 16'h3000;
    step();
    for (int k = 0; k < 5; k++) begin
      if (pmem_read === 1'b1 && pmem_address === 16'h3000) b_grants++;
      else break;
      pmem_resp = 1;
      step();
      pmem_resp = 0;
      #1;
      total++;
      if ({pmem_read, pmem_write} !== 2'b00) begin
        bad++; $display("FAIL starve_gap_recover k=%0d got=%b want=00", k, {pmem_read, pmem_write});
      end
      step();
      total++;
      if ({pmem_read, pmem_write} !== 2'b00) begin
        bad++; $display("FAIL starve_gap_idle k=%0d got=%b want=00", k, {pmem_read, pmem_write});
      end
      step();
    end
    total++;
    if (b_grants !== 4) begin
      bad++; $display("FAIL starve_b_count got=%0d want=4", b_grants);
    end
    total++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h7770) begin
      bad++; $display("FAIL starve_a_grant got=%b %h want=1 7770", pmem_read, pmem_address);
    end
    total++;
    if (dut.r_streak !== 4'd0) begin
      bad++; $display("FAIL starve_streak got=%0d want=0", dut.r_streak);
    end
    pmem_resp = 1;
    #1;
    total++;
    if ({pmem_resp_a, pmem_resp_b} !== 2'b10) begin
      bad++; $display("FAIL starve_a_resp got=%b want=10", {pmem_resp_a, pmem_resp_b});
    end
    step();
    pmem_resp = 0; pmem_read_a = 0; pmem_read_b = 0;
    step();
  endtask

  task automatic test_latch();
    pmem_read_b = 1; pmem_address_b = 16'h0010;
    step();
    pmem_address_b = 16'h0FF0; pmem_read_b = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (pmem_address !== 16'h0010 || pmem_read !== 1'b1) begin
        bad++; $display("FAIL latch_addr i=%0d got=%h %b want=0010 1", i, pmem_address, pmem_read);
      end
      step();
    end
    pmem_resp = 1;
    #1;
    total++;
    if (pmem_resp_b !== 1'b1 || pmem_address !== 16'h0010) begin
      bad++; $display("FAIL latch_resp got=%b %h want=1 0010", pmem_resp_b, pmem_address);
    end
    step();
    pmem_resp = 0;
    step();
  endtask

  task automatic test_reset_mid_op();
    pmem_read_a = 1; pmem_address_a = 16'h5550;
    step();
    total++;
    if (pmem_read !== 1'b1) begin
      bad++; $display("FAIL rst_mid_start got=%b want=1", pmem_read);
    end
    reset = 1; pmem_read_a = 0;
    step();
    reset = 0;
    #1;
    total++;
    if ({pmem_read, pmem_write, pmem_resp_a, pmem_resp_b} !== 4'b0000 ||
        pmem_address !== '0 || pmem_wdata !== '0) begin
      bad++; $display("FAIL rst_mid_outputs got=%b %h want=0000 0",
        {pmem_read, pmem_write, pmem_resp_a, pmem_resp_b}, pmem_address);
    end
    pmem_rdata = RD_A; pmem_resp = 1;
    #1;
    total++;
    if ({pmem_resp_a, pmem_resp_b} !== 2'b00 || pmem_rdata_a !== '0) begin
      bad++; $display("FAIL rst_mid_late_resp got=%b %h want=00 0",
        {pmem_resp_a, pmem_resp_b}, pmem_rdata_a);
    end
    step();
    total++;
    if ({pmem_resp_a, pmem_resp_b, pmem_read} !== 3'b000) begin
      bad++; $display("FAIL rst_mid_idle got=%b want=000", {pmem_resp_a, pmem_resp_b, pmem_read});
    end
    pmem_resp = 0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_a_only();
    test_b_write();
    test_contention();
    test_starvation();
    test_latch();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
